spi_route_ctrl: RTL and testbench
=================================

Name: spi_route_ctrl

Overview:
- Sys_clk-domain controller that selects which downstream SPI slave (1..NUM_SLAVES) receives each MCU SPI frame.
- The first byte of every CS-low frame is a routing header. It is consumed locally and never forwarded.
- After a valid header, exactly one one-hot select line is held for the remainder of the frame. The select lines drive the sw_flag inputs of the per-slave spi_module instances and of spi_rx.
- Sits between the MCU SPI pins and the fan-out/MISO-mux datapath.

Parameters:
- NUM_SLAVES, 7, number of downstream slaves; width of sel; legal range 1..7.
- HDR_MAGIC, 4'hA, required value of header[7:4].
- TIMEOUT_CYC, 480, sys_clk cycles with CS low and no SPI_CLK rising edge before the frame is aborted (10 us at 48 MHz).
- CNT_W, 16, width of frame_cnt.

Ports:
- sys_clk  input  1  system clock, 48 MHz.
- sys_rst  input  1  asynchronous active-high reset.
- spi_clk  input  1  MCU SPI clock, asynchronous, mode 0, at most 12 MHz.
- spi_cs  input  1  MCU chip select, active low, asynchronous.
- spi_mosi  input  1  MCU data, MSB first, asynchronous.
- sel  output  NUM_SLAVES  one-hot slave select; bit k selects slave k+1.
- route_valid  output  1  high while sel is non-zero.
- cur_target  output  3  index of the routed slave (1..7); 0 when not routing.
- hdr_err  output  1  one-cycle pulse on an invalid header.
- timeout_err  output  1  one-cycle pulse on a frame aborted by timeout.
- frame_cnt  output  CNT_W  count of successfully routed frames; wraps.

Behaviour:
- Reset (async assert, sync deassert inside the block): all outputs 0, state IDLE, synchronizers cleared. Reset mid-frame drops sel the same cycle; the current frame is ignored until CS goes high and then low again.
- Synchronization: spi_clk, spi_cs and spi_mosi each pass through a 2-flop synchronizer plus one edge-detect register. An SPI_CLK rising edge is recognised 3 sys_clk cycles after the pin edge. spi_mosi is sampled on that same recognised edge.
- Bit counter: 3 bits; shift register: 8 bits, shifting MSB first.
- States:
  - IDLE: bit counter cleared. Synced CS falling -> HEADER.
  - HEADER: shift one bit per recognised SPI_CLK rise. After the 8th bit, evaluate the header:
    - Valid when header[7:4] == HDR_MAGIC and header[2:0] is in 1..NUM_SLAVES; header[3] is ignored. Valid -> ROUTE.
    - Otherwise pulse hdr_err -> DRAIN.
  - ROUTE: sel[t-1] = 1, cur_target = t, route_valid = 1, all registered; they rise 1 cycle after header evaluation. frame_cnt increments on entry and wraps from all-ones to 0. Synced CS rising -> IDLE; sel, route_valid and cur_target clear the same cycle.
  - DRAIN: all outputs inactive. Synced CS rising -> IDLE.
- Timeout: in HEADER only, a TIMEOUT_CYC counter is reset by every recognised SPI_CLK rise. On reaching TIMEOUT_CYC - 1: pulse timeout_err -> DRAIN. ROUTE has no timeout, because the MCU may pause between data bytes.
- CS rising while in HEADER (fewer than 8 bits): -> IDLE. No error pulse and no count.
- CS rise and CS fall within the same synced cycle cannot occur. The minimum CS-high time is 4 sys_clk cycles, guaranteed by the MCU firmware.
- Header-to-data timing: sel is valid 5 sys_clk cycles after the 8th SPI_CLK rising pin edge. The MCU inserts at least 200 ns of gap before the 9th SPI_CLK edge. This is a firmware contract, not checked by the block.
- sel is always one-hot or zero. Never more than one bit is set.

Test Plan:
- Header 8'hA3 at 12 MHz, then 4 data bytes, CS high -> sel = 7'b0000100 and cur_target = 3 from 5 cycles after bit 8 until CS rise; frame_cnt 0 -> 1; no error pulses.
- Header 8'h57 (bad magic) -> hdr_err pulses once; sel stays 0 through the whole frame; frame_cnt unchanged; the next frame with header 8'hA7 gives sel = 7'b1000000.
- Header 8'hA0 and header 8'hA8 (target 0) -> hdr_err each time. With NUM_SLAVES = 4, header 8'hA5 -> hdr_err.
- CS low, send 5 bits, then stall SPI_CLK for 500 sys_clk cycles -> timeout_err pulses at 480 cycles after the last edge; state DRAIN until CS rises; the next valid frame routes normally.
- Assert sys_rst mid-ROUTE with sel = 7'b0000010 -> sel = 0 and frame_cnt = 0 immediately. Release reset with CS still low -> no routing until a CS high-then-low sequence.
- Preload frame_cnt near the top (65535 frames, or CNT_W = 4 with 15 frames), then one more valid frame -> frame_cnt wraps to 0. A 3-bit partial header followed by CS rise -> no errors, no count.

Source files
------------

// File: rtl/spi_route_ctrl_if.sv
// spi_route_ctrl_if: MCU SPI pins in, slave-select routing status out
// Ports (master = bench/MCU side, slave = spi_route_ctrl side):
//   spi_clk, spi_cs, spi_mosi  raw asynchronous MCU SPI pins
//   sel                        one-hot downstream slave select
//   route_valid, cur_target    routing status
//   hdr_err, timeout_err       one-cycle error pulses
//   frame_cnt                  count of successfully routed frames
interface spi_route_ctrl_if #(
   parameter int NUM_SLAVES = 7,
   parameter int CNT_W      = 16
);
   logic                  spi_clk;
   logic                  spi_cs;
   logic                  spi_mosi;
   logic [NUM_SLAVES-1:0] sel;
   logic                  route_valid;
   logic [2:0]            cur_target;
   logic                  hdr_err;
   logic                  timeout_err;
   logic [CNT_W-1:0]      frame_cnt;
   modport master (
      output spi_clk, spi_cs, spi_mosi,
      input  sel, route_valid, cur_target, hdr_err, timeout_err, frame_cnt
   );
   modport slave (
      input  spi_clk, spi_cs, spi_mosi,
      output sel, route_valid, cur_target, hdr_err, timeout_err, frame_cnt
   );
endinterface

// File: rtl/spi_route_ctrl.sv
// spi_route_ctrl: routes each MCU SPI frame to one downstream slave chosen by its header byte
// Ports:
//   sys_clk  system clock
//   sys_rst  asynchronous active-high reset (released synchronously inside)
//   bus      spi_route_ctrl_if.slave: SPI pins in; sel/route_valid/cur_target,
//            hdr_err/timeout_err pulses and frame_cnt out
module spi_route_ctrl #(
   parameter int         NUM_SLAVES  = 7,
   parameter logic [3:0] HDR_MAGIC   = 4'hA,
   parameter int         TIMEOUT_CYC = 480,
   parameter int         CNT_W       = 16
) (
   input logic           sys_clk,
   input logic           sys_rst,
   spi_route_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HEADER = 2'd1;
   localparam logic [1:0] ROUTE  = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;
   localparam int         TO_W   = $clog2(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0] MAX_T  = 3'(NUM_SLAVES);

   logic [1:0]      rst_sync;
   logic            rst;
   logic [2:0]      clk_sr, cs_sr, mosi_sr;
   logic            sck_rise, cs_rise, cs_fall, hdr_ok;
   logic [1:0]      state;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            hdr_done;
   logic [2:0]      tgt;
   logic [TO_W-1:0] to_cnt;

   // reset asserts immediately but releases on a clock edge
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) rst_sync <= 2'b11;
      else rst_sync <= {rst_sync[0], 1'b0};
   assign rst = rst_sync[1];

   // [0],[1] form the 2-flop synchronizer, [2] is the edge-detect register;
   // clearing them on reset means a CS held low through reset never looks like a fall
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         clk_sr  <= '0;
         cs_sr   <= '0;
         mosi_sr <= '0;
      end else begin
         clk_sr  <= {clk_sr[1:0], bus.spi_clk};
         cs_sr   <= {cs_sr[1:0], bus.spi_cs};
         mosi_sr <= {mosi_sr[1:0], bus.spi_mosi};
      end

   assign sck_rise = clk_sr[1] & ~clk_sr[2];
   assign cs_rise  = cs_sr[1] & ~cs_sr[2];
   assign cs_fall  = ~cs_sr[1] & cs_sr[2];
   // header bit 3 is reserved and masked out of the magic compare
   assign hdr_ok   = ((shreg & 8'hF0) == {HDR_MAGIC, 4'h0}) && (shreg[2:0] != 3'd0) && (shreg[2:0] <= MAX_T);

   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         state           <= IDLE;
         bit_cnt         <= '0;
         shreg           <= '0;
         hdr_done        <= 1'b0;
         tgt             <= '0;
         to_cnt          <= '0;
         bus.sel         <= '0;
         bus.route_valid <= 1'b0;
         bus.cur_target  <= '0;
         bus.hdr_err     <= 1'b0;
         bus.timeout_err <= 1'b0;
         bus.frame_cnt   <= '0;
      end else begin
         bus.hdr_err     <= 1'b0;
         bus.timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt  <= '0;
               hdr_done <= 1'b0;
               to_cnt   <= '0;
               if (cs_fall) state <= HEADER;
            end
            HEADER:
               if (cs_rise) state <= IDLE;
               // evaluation runs one cycle after the 8th bit lands in shreg
               else if (hdr_done) begin
                  hdr_done <= 1'b0;
                  if (hdr_ok) begin
                     state         <= ROUTE;
                     tgt           <= shreg[2:0];
                     bus.frame_cnt <= bus.frame_cnt + CNT_W'(1);
                  end else begin
                     state       <= DRAIN;
                     bus.hdr_err <= 1'b1;
                  end
               end else if (sck_rise) begin
                  shreg    <= {shreg[6:0], mosi_sr[2]};
                  bit_cnt  <= bit_cnt + 3'd1;
                  hdr_done <= (bit_cnt == 3'd7);
                  to_cnt   <= '0;
               end else if (to_cnt == TO_LAST) begin
                  state           <= DRAIN;
                  bus.timeout_err <= 1'b1;
               end else to_cnt <= to_cnt + TO_W'(1);
            ROUTE:
               if (cs_rise) begin
                  state           <= IDLE;
                  bus.sel         <= '0;
                  bus.route_valid <= 1'b0;
                  bus.cur_target  <= '0;
               end else begin
                  bus.sel         <= NUM_SLAVES'(1) << (tgt - 3'd1);
                  bus.route_valid <= 1'b1;
                  bus.cur_target  <= tgt;
               end
            default:
               if (cs_rise) state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_route_ctrl.sv
// tb_spi_route_ctrl: directed frames into two spi_route_ctrl instances (7 slaves/16-bit count, 4 slaves/4-bit count) checked every cycle against an event-timed model
module tb_spi_route_ctrl;
   localparam int BIG = 1 << 30;
   logic sys_clk = 1'b0, sys_rst = 1'b1, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
   int cyc = 0, vectors = 0, miscompares = 0;
   int ns [2]    = '{7, 4};
   int cmask [2] = '{32'hFFFF, 32'hF};
   int tgt_m [2], lo [2], hi [2], cnt_base [2], inc_at [2];
   int herr_at [2] = '{-1, -1};
   int to_at [2]   = '{-1, -1};

   always #10 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   spi_route_ctrl_if #(.NUM_SLAVES(7), .CNT_W(16)) b0 ();
   spi_route_ctrl_if #(.NUM_SLAVES(4), .CNT_W(4))  b1 ();
   assign b0.spi_clk = sck;
   assign b0.spi_cs = cs;
   assign b0.spi_mosi = mosi;
   assign b1.spi_clk = sck;
   assign b1.spi_cs = cs;
   assign b1.spi_mosi = mosi;

   spi_route_ctrl #(.NUM_SLAVES(7), .CNT_W(16)) u0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b0));
   spi_route_ctrl #(.NUM_SLAVES(4), .CNT_W(4))  u1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b1));

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s[u%0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge sys_clk);
         #2;
      end
   endtask

   // mode 0 at sys_clk/4: MOSI set with SCK low, SCK high two cycles later
   task automatic send_bits(input logic [7:0] b, input int n, output int last);
      for (int k = 7; k > 7 - n; k--) begin
         mosi = b[k];
         sck = 1'b0;
         tick(2);
         sck = 1'b1;
         last = cyc;
         tick(2);
      end
      sck = 1'b0;
      tick(1);
   endtask

   task automatic start_frame();
      for (int i = 0; i < 2; i++) begin
         if (cyc >= inc_at[i]) cnt_base[i]++;
         inc_at[i] = BIG;
         lo[i] = BIG;
         hi[i] = BIG;
      end
      cs = 1'b0;
      tick(4);
   endtask

   // pin edge at cycle e: header judged at e+4 (error pulse, count), select visible from e+5
   task automatic open_frame(input logic [7:0] hdr);
      int e;
      start_frame();
      send_bits(hdr, 8, e);
      for (int i = 0; i < 2; i++)
         if (hdr[7:4] == 4'hA && hdr[2:0] != 3'd0 && int'(hdr[2:0]) <= ns[i]) begin
            tgt_m[i] = int'(hdr[2:0]);
            lo[i] = e + 5;
            inc_at[i] = e + 4;
         end else herr_at[i] = e + 4;
   endtask

   task automatic data(input int n);
      int e;
      for (int k = 0; k < n; k++) send_bits(8'(8'h3C + 8'(k * 37)), 8, e);
   endtask

   task automatic close_frame();
      cs = 1'b1;
      for (int i = 0; i < 2; i++) hi[i] = cyc + 3;
      tick(6);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cnt_base[i] = 0;
         inc_at[i] = BIG;
         lo[i] = BIG;
         hi[i] = BIG;
      end
      #1;
      chk("rst_sel", 0, 32'(b0.sel), 32'h0);
      chk("rst_cnt", 0, 32'(b0.frame_cnt), 32'h0);
      chk("rst_valid", 0, 32'(b0.route_valid), 32'h0);
      tick(3);
      sys_rst = 1'b0;
      tick(3);
   endtask

   always @(negedge sys_clk)
      for (int i = 0; i < 2; i++) begin
         logic w;
         logic [31:0] es, ec;
         w = cyc >= lo[i] && cyc < hi[i];
         es = w ? 32'd1 << (tgt_m[i] - 1) : 32'd0;
         ec = 32'((cnt_base[i] + (cyc >= inc_at[i] ? 1 : 0)) & cmask[i]);
         chk("sel", i, i == 0 ? 32'(b0.sel) : 32'(b1.sel), es);
         chk("route_valid", i, i == 0 ? 32'(b0.route_valid) : 32'(b1.route_valid), 32'(w));
         chk("cur_target", i, i == 0 ? 32'(b0.cur_target) : 32'(b1.cur_target), w ? 32'(tgt_m[i]) : 32'd0);
         chk("hdr_err", i, i == 0 ? 32'(b0.hdr_err) : 32'(b1.hdr_err), 32'(cyc == herr_at[i]));
         chk("timeout_err", i, i == 0 ? 32'(b0.timeout_err) : 32'(b1.timeout_err), 32'(cyc == to_at[i]));
         chk("frame_cnt", i, i == 0 ? 32'(b0.frame_cnt) : 32'(b1.frame_cnt), ec);
      end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int e;
      for (int i = 0; i < 2; i++) begin
         lo[i] = BIG;
         hi[i] = BIG;
         inc_at[i] = BIG;
         cnt_base[i] = 0;
         tgt_m[i] = 0;
      end
      tick(5);
      sys_rst = 1'b0;
      tick(5);
      chk("init_sel", 0, 32'(b0.sel), 32'h0);
      chk("init_cnt", 0, 32'(b0.frame_cnt), 32'h0);
      open_frame(8'hA3);
      data(4);
      chk("a3_sel", 0, 32'(b0.sel), 32'h04);
      chk("a3_tgt", 0, 32'(b0.cur_target), 32'd3);
      chk("a3_sel", 1, 32'(b1.sel), 32'h04);
      close_frame();
      chk("a3_cnt", 0, 32'(b0.frame_cnt), 32'd1);
      chk("a3_sel_off", 0, 32'(b0.sel), 32'h0);
      open_frame(8'h57);
      data(2);
      chk("57_sel", 0, 32'(b0.sel), 32'h0);
      close_frame();
      chk("57_cnt", 0, 32'(b0.frame_cnt), 32'd1);
      open_frame(8'hA7);
      data(1);
      chk("a7_sel", 0, 32'(b0.sel), 32'h40);
      chk("a7_sel", 1, 32'(b1.sel), 32'h0);
      close_frame();
      open_frame(8'hA0);
      data(1);
      close_frame();
      open_frame(8'hA8);
      data(1);
      close_frame();
      open_frame(8'hA5);
      data(1);
      close_frame();
      chk("a5_cnt", 0, 32'(b0.frame_cnt), 32'd3);
      chk("a5_cnt", 1, 32'(b1.frame_cnt), 32'd1);
      start_frame();
      send_bits(8'hA5, 5, e);
      for (int i = 0; i < 2; i++) to_at[i] = e + 483;
      tick(500);
      close_frame();
      open_frame(8'hA4);
      data(1);
      chk("a4_sel", 0, 32'(b0.sel), 32'h08);
      close_frame();
      open_frame(8'hA2);
      data(1);
      chk("a2_sel", 0, 32'(b0.sel), 32'h02);
      do_reset();
      send_bits(8'hA1, 8, e);
      data(1);
      tick(10);
      chk("cs_held_sel", 0, 32'(b0.sel), 32'h0);
      chk("cs_held_valid", 0, 32'(b0.route_valid), 32'h0);
      close_frame();
      start_frame();
      send_bits(8'hA1, 3, e);
      close_frame();
      chk("partial_cnt", 0, 32'(b0.frame_cnt), 32'd0);
      for (int k = 0; k < 16; k++) begin
         open_frame(8'(8'hA1 + 8'(k % 4)));
         close_frame();
      end
      chk("wrap_cnt", 0, 32'(b0.frame_cnt), 32'd16);
      chk("wrap_cnt", 1, 32'(b1.frame_cnt), 32'd0);
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
